memory_arbiter: RTL and testbench
=================================

# memory_arbiter

Shares the single-port 16-bit instruction/data memory between the CPU core and the host program-loader port. It does one transaction at a time and arbitrates with CPU priority. Starvation protection and a loader lock let the loader make progress. A stall output freezes the phase counter while the CPU waits. It sits between the CPU controller / loader and the memory wrapper.

## Interface
- READ_LATENCY, 1: memory cycles from mem_en to valid mem_rdata (1..4).
- STARVE_LIMIT, 8: consecutive ungranted loader-request cycles that force a loader win (2..255).
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_req, cpu_we  in  1,1  CPU request / write enable.
- cpu_addr, cpu_wdata  in  16,16  CPU address / write data.
- cpu_gnt  out  1  one-cycle pulse: CPU transaction issued to memory.
- cpu_rvalid  out  1  one-cycle pulse: cpu_rdata valid.
- cpu_rdata  out  16  CPU read data (registered, holds until next CPU read).
- cpu_stall  out  1  cpu_req high and not granted this cycle (combinational).
- ld_req, ld_we, ld_lock  in  1,1,1  loader request / write enable / bus lock.
- ld_addr, ld_wdata  in  16,16  loader address / write data.
- ld_gnt, ld_rvalid  out  1,1  same semantics as the CPU port.
- ld_rdata  out  16  loader read data.
- mem_en, mem_we  out  1,1  memory access strobe / write (registered).
- mem_addr, mem_wdata  out  16,16  memory address / write data (registered).
- mem_rdata  in  16  memory read data.

## Operation
- FSM states: IDLE, ACCESS, WAIT. One outstanding transaction at most.
- IDLE: sample requests; if any wins → ACCESS next cycle with the winner's we/addr/wdata latched into the mem_* registers; otherwise stay.
- Winner selection, in priority order:
  - lock_owner_ld set and ld_req → loader;
  - starve_cnt == STARVE_LIMIT and ld_req → loader;
  - cpu_req → CPU;
  - ld_req → loader.
- lock_owner_ld: set on a loader grant while ld_lock=1. Cleared when ld_lock=0. While set, the CPU is never granted, even if ld_req is low.
- starve_cnt: +1 each IDLE cycle with ld_req=1 and CPU winning; saturates at STARVE_LIMIT; cleared on any loader grant.
- ACCESS: mem_en=1 for exactly one cycle; winner's gnt pulses the same cycle. Write → IDLE. Read → WAIT with lat_cnt=READ_LATENCY−1.
- WAIT: decrement lat_cnt; at 0 capture mem_rdata into the owner's rdata register, pulse that port's rvalid the next cycle, → IDLE.
- Requester holds req/we/addr/wdata stable until gnt. A req dropped before being sampled in IDLE is withdrawn. Once sampled, the transaction is committed.
- Reset (any time, mid-transaction included): state IDLE, mem_en/mem_we=0, mem_addr/mem_wdata=0, all gnt/rvalid=0, rdata=0, starve_cnt=0, lock_owner_ld=0; aborted reads produce no rvalid.

## Timing
- Request sampled in IDLE at cycle N: gnt + mem_en in N+1.
- Read rvalid in N+2+READ_LATENCY (N+3 at default).
- Write occupies 2 cycles; back-to-back writes: one per 2 cycles. Read occupies 2+READ_LATENCY cycles.
- Simultaneous cpu_req/ld_req in IDLE: CPU wins unless lock or starvation rule applies.
- cpu_stall is combinational from cpu_req and internal state. It is low only in the ACCESS cycle granting the CPU, or when cpu_req=0.
- rvalid pulse can coincide with IDLE sampling a new request (pipelined re-arbitration, no dead cycle).

## Structure
- Shared package mem_arb_pkg:
  - FSM state encoding (IDLE/ACCESS/WAIT);
  - port index constants PORT_CPU=0, PORT_LD=1;
  - the shared instruction-fetch/load memory width constant (16).
- One sub-module: starve_counter (saturating counter with clear and limit-reached flag, parameter STARVE_LIMIT).

## Test plan
- CPU read addr 0x0010, mem_rdata=0xBEEF: cpu_gnt at N+1, mem_addr=0x0010, cpu_rvalid at N+3 with cpu_rdata=0xBEEF; ld_* outputs silent.
- Simultaneous CPU write 0x0020←0x1234 and loader write 0x0030←0x5678: CPU granted first at N+1, loader granted at N+3. mem_wdata matches each.
- cpu_req held continuously, ld_req high: loader granted after starve_cnt reaches 8, i.e. within 8 CPU transactions; starve_cnt then clears.
- Loader grant with ld_lock=1, then ld_req toggled with cpu_req held: CPU never granted and cpu_stall=1 until ld_lock=0. CPU granted on the next IDLE.
- Reset asserted in WAIT of a loader read: all outputs 0 immediately, no ld_rvalid after release, next CPU request served normally.
- READ_LATENCY=3: CPU read rvalid exactly at N+5; cpu_stall low only in the grant cycle.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the CPU / program-loader memory arbiter.
package mem_arb_pkg;
    localparam int unsigned MEM_W    = 16;
    localparam int unsigned PORT_CPU = 0;
    localparam int unsigned PORT_LD  = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic             we;
        logic [MEM_W-1:0] addr;
        logic [MEM_W-1:0] wdata;
    } mem_req_t;
endpackage

// File: rtl/memory_arbiter_starve_counter.sv
// Saturating count of loader-request cycles lost to the CPU; flags when the limit is reached.
module starve_counter #(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_limit_c
);
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_W'(STARVE_LIMIT))) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign at_limit_c = (cnt == CNT_W'(STARVE_LIMIT));
endmodule

// File: rtl/memory_arbiter.sv
// Single-transaction arbiter sharing one memory port between the CPU and the loader.
module memory_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [MEM_W-1:0] cpu_addr,
    input  logic [MEM_W-1:0] cpu_wdata,
    output logic             cpu_gnt,
    output logic             cpu_rvalid,
    output logic [MEM_W-1:0] cpu_rdata,
    output logic             cpu_stall,
    input  logic             ld_req,
    input  logic             ld_we,
    input  logic             ld_lock,
    input  logic [MEM_W-1:0] ld_addr,
    input  logic [MEM_W-1:0] ld_wdata,
    output logic             ld_gnt,
    output logic             ld_rvalid,
    output logic [MEM_W-1:0] ld_rdata,
    output logic             mem_en,
    output logic             mem_we,
    output logic [MEM_W-1:0] mem_addr,
    output logic [MEM_W-1:0] mem_wdata,
    input  logic [MEM_W-1:0] mem_rdata
);
    localparam int unsigned LAT_W   = 2;
    localparam logic        CPU_SEL = 1'(PORT_CPU);
    localparam logic        LD_SEL  = 1'(PORT_LD);

    arb_state_e       state, state_nxt;
    logic             owner;
    logic [LAT_W-1:0] lat_cnt;
    logic             lock_owner_ld;
    logic             starve_hit;
    logic             cpu_win, ld_win;
    logic             issue, issue_port, capture;
    logic             starve_inc, starve_clr;
    mem_req_t         sel_req;

    assign starve_inc = (state == IDLE) && ld_req && cpu_win;
    assign starve_clr = issue && (issue_port == LD_SEL);

    starve_counter #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
        .clock      (clock),
        .reset      (reset),
        .inc        (starve_inc),
        .clr        (starve_clr),
        .at_limit_c (starve_hit)
    );

    // Winner selection: lock owner, then starved loader, then CPU, then loader.
    always_comb begin
        cpu_win = 1'b0;
        ld_win  = 1'b0;
        if (lock_owner_ld) begin
            ld_win = ld_req;
        end else if (starve_hit && ld_req) begin
            ld_win = 1'b1;
        end else if (cpu_req) begin
            cpu_win = 1'b1;
        end else begin
            ld_win = ld_req;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        issue      = 1'b0;
        issue_port = CPU_SEL;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_win || ld_win) begin
                    issue      = 1'b1;
                    issue_port = ld_win ? LD_SEL : CPU_SEL;
                    state_nxt  = ACCESS;
                end
            end
            ACCESS:  state_nxt = mem_we ? IDLE : WAIT;
            WAIT: begin
                if (lat_cnt == '0) begin
                    capture   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sel_req = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
        if (issue_port == LD_SEL) sel_req = '{we: ld_we, addr: ld_addr, wdata: ld_wdata};
    end

    // Memory strobes, grant/valid pulses, read-data capture and lock ownership.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_en        <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            cpu_gnt       <= 1'b0;
            ld_gnt        <= 1'b0;
            cpu_rvalid    <= 1'b0;
            ld_rvalid     <= 1'b0;
            cpu_rdata     <= '0;
            ld_rdata      <= '0;
            owner         <= CPU_SEL;
            lat_cnt       <= '0;
            lock_owner_ld <= 1'b0;
        end else begin
            mem_en     <= issue;
            mem_we     <= issue && sel_req.we;
            cpu_gnt    <= issue && (issue_port == CPU_SEL);
            ld_gnt     <= issue && (issue_port == LD_SEL);
            cpu_rvalid <= capture && (owner == CPU_SEL);
            ld_rvalid  <= capture && (owner == LD_SEL);
            if (issue) begin
                owner     <= issue_port;
                mem_addr  <= sel_req.addr;
                mem_wdata <= sel_req.wdata;
            end
            if (state == ACCESS) begin
                lat_cnt <= LAT_W'(READ_LATENCY - 1);
            end else if ((state == WAIT) && (lat_cnt != '0)) begin
                lat_cnt <= lat_cnt - LAT_W'(1);
            end
            if (capture && (owner == CPU_SEL)) cpu_rdata <= mem_rdata;
            if (capture && (owner == LD_SEL))  ld_rdata  <= mem_rdata;
            if (!ld_lock) begin
                lock_owner_ld <= 1'b0;
            end else if (issue && (issue_port == LD_SEL)) begin
                lock_owner_ld <= 1'b1;
            end
        end
    end

    // A requesting CPU is stalled in every cycle except its grant cycle.
    assign cpu_stall = cpu_req && !cpu_gnt;
endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed scenarios plus a randomized run against a cycle-budget model.
module tb_memory_arbiter;
    localparam int unsigned RL    = 1;
    localparam int unsigned LIMIT = 8;
    localparam int          NCYC  = 800;

    logic        clock;
    logic        reset;
    logic        cpu_req, cpu_we, ld_req, ld_we, ld_lock;
    logic [15:0] cpu_addr, cpu_wdata, ld_addr, ld_wdata, mem_rdata;
    logic        cpu_gnt, cpu_rvalid, cpu_stall, ld_gnt, ld_rvalid, mem_en, mem_we;
    logic [15:0] cpu_rdata, ld_rdata, mem_addr, mem_wdata;
    logic        cpu_gnt3, cpu_rvalid3, cpu_stall3, ld_gnt3, ld_rvalid3, mem_en3, mem_we3;
    logic [15:0] cpu_rdata3, ld_rdata3, mem_addr3, mem_wdata3;

    int checks = 0;
    int errors = 0;

    memory_arbiter #(.READ_LATENCY(RL), .STARVE_LIMIT(LIMIT)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .ld_req(ld_req), .ld_we(ld_we), .ld_lock(ld_lock), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    memory_arbiter #(.READ_LATENCY(3), .STARVE_LIMIT(LIMIT)) dut3 (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt3), .cpu_rvalid(cpu_rvalid3), .cpu_rdata(cpu_rdata3), .cpu_stall(cpu_stall3),
        .ld_req(ld_req), .ld_we(ld_we), .ld_lock(ld_lock), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(ld_gnt3), .ld_rvalid(ld_rvalid3), .ld_rdata(ld_rdata3),
        .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
        .mem_rdata(mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_idle();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        ld_req = 1'b0; ld_we = 1'b0; ld_lock = 1'b0; ld_addr = '0; ld_wdata = '0;
    endtask

    task automatic test_reset();
        logic [69:0] v;
        drive_idle();
        reset = 1'b0;
        mem_rdata = '0;
        repeat (2) tick();
        v = {cpu_gnt, cpu_rvalid, cpu_rdata, ld_gnt, ld_rvalid, ld_rdata, mem_en, mem_we, mem_addr, mem_wdata};
        checks++;
        if (v !== 70'h0) begin errors++; $display("FAIL reset_outputs: got %h exp 0", v); end
        v = {cpu_gnt3, cpu_rvalid3, cpu_rdata3, ld_gnt3, ld_rvalid3, ld_rdata3, mem_en3, mem_we3, mem_addr3, mem_wdata3};
        checks++;
        if (v !== 70'h0) begin errors++; $display("FAIL reset_outputs_rl3: got %h exp 0", v); end
        checks++;
        if (cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall_idle: got %b exp 0", cpu_stall); end
        cpu_req = 1'b1;
        #1;
        checks++;
        if (cpu_stall !== 1'b1) begin errors++; $display("FAIL reset_stall_req: got %b exp 1", cpu_stall); end
        cpu_req = 1'b0;
        @(negedge clock) reset = 1'b1;
        tick();
    endtask

    task automatic test_cpu_read();
        mem_rdata = 16'hBEEF;
        tick();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
        #1;
        checks++;
        if (cpu_stall !== 1'b1) begin errors++; $display("FAIL cpu_read_stall_n: got %b exp 1", cpu_stall); end
        tick();
        checks++;
        if ({cpu_gnt, ld_gnt, mem_en, mem_we, cpu_stall} !== 5'b10100) begin
            errors++; $display("FAIL cpu_read_grant: got %b exp 10100", {cpu_gnt, ld_gnt, mem_en, mem_we, cpu_stall});
        end
        checks++;
        if (mem_addr !== 16'h0010) begin errors++; $display("FAIL cpu_read_addr: got %h exp 0010", mem_addr); end
        cpu_req = 1'b0;
        tick();
        checks++;
        if ({cpu_gnt, cpu_rvalid, mem_en, ld_gnt, ld_rvalid} !== 5'b0) begin
            errors++; $display("FAIL cpu_read_wait: got %b exp 00000", {cpu_gnt, cpu_rvalid, mem_en, ld_gnt, ld_rvalid});
        end
        tick();
        checks++;
        if ({cpu_rvalid, ld_rvalid, ld_gnt, cpu_rdata, ld_rdata} !== {3'b100, 16'hBEEF, 16'h0000}) begin
            errors++; $display("FAIL cpu_read_data: got %b %h %h exp 100 beef 0000",
                               {cpu_rvalid, ld_rvalid, ld_gnt}, cpu_rdata, ld_rdata);
        end
        tick();
        checks++;
        if ({cpu_rvalid, cpu_rdata} !== {1'b0, 16'hBEEF}) begin
            errors++; $display("FAIL cpu_read_hold: got %b %h exp 0 beef", cpu_rvalid, cpu_rdata);
        end
    endtask

    task automatic test_simultaneous_writes();
        tick();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0020; cpu_wdata = 16'h1234;
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 16'h0030; ld_wdata = 16'h5678;
        tick();
        checks++;
        if ({cpu_gnt, ld_gnt, mem_en, mem_we, mem_addr, mem_wdata} !== {4'b1011, 16'h0020, 16'h1234}) begin
            errors++; $display("FAIL simul_cpu_first: got %b %h %h exp 1011 0020 1234",
                               {cpu_gnt, ld_gnt, mem_en, mem_we}, mem_addr, mem_wdata);
        end
        cpu_req = 1'b0;
        tick();
        checks++;
        if ({cpu_gnt, ld_gnt, mem_en} !== 3'b000) begin
            errors++; $display("FAIL simul_gap: got %b exp 000", {cpu_gnt, ld_gnt, mem_en});
        end
        tick();
        checks++;
        if ({cpu_gnt, ld_gnt, mem_en, mem_we, mem_addr, mem_wdata} !== {4'b0111, 16'h0030, 16'h5678}) begin
            errors++; $display("FAIL simul_ld_second: got %b %h %h exp 0111 0030 5678",
                               {cpu_gnt, ld_gnt, mem_en, mem_we}, mem_addr, mem_wdata);
        end
        ld_req = 1'b0;
        tick();
    endtask

    task automatic test_starvation();
        int  cpu_grants = 0;
        bit  ld_seen = 1'b0;
        tick();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0400; cpu_wdata = 16'($urandom);
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 16'h0100; ld_wdata = 16'hA5A5;
        for (int i = 0; i < 40 && !ld_seen; i++) begin
            tick();
            if (cpu_gnt === 1'b1) begin
                cpu_grants++;
                cpu_addr = 16'($urandom); cpu_wdata = 16'($urandom);
            end
            if (ld_gnt === 1'b1) ld_seen = 1'b1;
        end
        checks++;
        if (!ld_seen || cpu_grants != 8) begin
            errors++; $display("FAIL starve_cpu_grants: got %0d (loader seen %b) exp 8 (loader seen 1)", cpu_grants, ld_seen);
        end
        checks++;
        if ({cpu_stall, mem_addr, mem_wdata} !== {1'b1, 16'h0100, 16'hA5A5}) begin
            errors++; $display("FAIL starve_ld_access: got %b %h %h exp 1 0100 a5a5", cpu_stall, mem_addr, mem_wdata);
        end
        ld_addr = 16'h0101;
        tick();
        tick();
        checks++;
        if ({cpu_gnt, ld_gnt} !== 2'b10) begin
            errors++; $display("FAIL starve_cleared: got %b exp 10", {cpu_gnt, ld_gnt});
        end
        cpu_req = 1'b0; ld_req = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_lock();
        tick();
        ld_req = 1'b1; ld_we = 1'b1; ld_lock = 1'b1; ld_addr = 16'h0200; ld_wdata = 16'h0F0F;
        tick();
        checks++;
        if (ld_gnt !== 1'b1) begin errors++; $display("FAIL lock_ld_grant: got %b exp 1", ld_gnt); end
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0300; cpu_wdata = 16'h3333;
        for (int i = 0; i < 15; i++) begin
            ld_req  = (i < 12) ? 1'($urandom) : 1'b0;
            ld_addr = 16'($urandom);
            #1;
            checks++;
            if ({cpu_gnt, cpu_stall} !== 2'b01) begin
                errors++; $display("FAIL lock_cpu_blocked: cycle %0d got %b exp 01", i, {cpu_gnt, cpu_stall});
            end
            tick();
        end
        ld_lock = 1'b0;
        tick();
        checks++;
        if (cpu_gnt !== 1'b0) begin errors++; $display("FAIL lock_release_early: got %b exp 0", cpu_gnt); end
        tick();
        checks++;
        if ({cpu_gnt, cpu_stall} !== 2'b10) begin
            errors++; $display("FAIL lock_release_grant: got %b exp 10", {cpu_gnt, cpu_stall});
        end
        cpu_req = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_reset_in_wait();
        logic [69:0] v;
        bit          rv_seen = 1'b0;
        tick();
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = 16'h0040; mem_rdata = 16'h1111;
        tick();
        checks++;
        if ({ld_gnt, mem_en, mem_we} !== 3'b110) begin
            errors++; $display("FAIL rst_ld_grant: got %b exp 110", {ld_gnt, mem_en, mem_we});
        end
        ld_req = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        v = {cpu_gnt, cpu_rvalid, cpu_rdata, ld_gnt, ld_rvalid, ld_rdata, mem_en, mem_we, mem_addr, mem_wdata};
        checks++;
        if (v !== 70'h0) begin errors++; $display("FAIL rst_in_wait_outputs: got %h exp 0", v); end
        @(negedge clock) reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ld_rvalid !== 1'b0 || ld_rvalid3 !== 1'b0) rv_seen = 1'b1;
        end
        checks++;
        if (rv_seen) begin errors++; $display("FAIL rst_no_rvalid: got 1 exp 0"); end
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0050; mem_rdata = 16'h2222;
        tick();
        checks++;
        if ({cpu_gnt, mem_en, mem_addr} !== {2'b11, 16'h0050}) begin
            errors++; $display("FAIL rst_cpu_grant: got %b %h exp 11 0050", {cpu_gnt, mem_en}, mem_addr);
        end
        cpu_req = 1'b0;
        repeat (2) tick();
        checks++;
        if ({cpu_rvalid, cpu_rdata} !== {1'b1, 16'h2222}) begin
            errors++; $display("FAIL rst_cpu_read: got %b %h exp 1 2222", cpu_rvalid, cpu_rdata);
        end
    endtask

    task automatic test_latency3();
        repeat (4) tick();
        mem_rdata = 16'hFFFF;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0060;
        #1;
        checks++;
        if (cpu_stall3 !== 1'b1) begin errors++; $display("FAIL rl3_stall_n: got %b exp 1", cpu_stall3); end
        tick();
        checks++;
        if ({cpu_gnt3, mem_en3, cpu_stall3, mem_addr3} !== {3'b110, 16'h0060}) begin
            errors++; $display("FAIL rl3_grant: got %b %h exp 110 0060", {cpu_gnt3, mem_en3, cpu_stall3}, mem_addr3);
        end
        for (int k = 2; k <= 4; k++) begin
            tick();
            mem_rdata = (k == 4) ? 16'hC0DE : 16'hFFFF;
            checks++;
            if ({cpu_gnt3, cpu_rvalid3, cpu_stall3} !== 3'b001) begin
                errors++; $display("FAIL rl3_waiting: cycle N+%0d got %b exp 001", k, {cpu_gnt3, cpu_rvalid3, cpu_stall3});
            end
        end
        tick();
        mem_rdata = 16'hFFFF;
        checks++;
        if ({cpu_rvalid3, cpu_rdata3} !== {1'b1, 16'hC0DE}) begin
            errors++; $display("FAIL rl3_rvalid: got %b %h exp 1 c0de", cpu_rvalid3, cpu_rdata3);
        end
        cpu_req = 1'b0;
        tick();
    endtask

    task automatic test_random();
        bit          e_cg[0:1023], e_lg[0:1023], e_cv[0:1023], e_lv[0:1023], e_en[0:1023];
        logic [32:0] e_req[0:1023];
        logic [15:0] hist[0:1023];
        logic [15:0] e_crd, e_lrd;
        logic [32:0] got;
        int          busy, starve, win, cpu_rate;
        bit          lock, c_pend, l_pend;
        for (int i = 0; i < 1024; i++) begin
            e_cg[i] = 0; e_lg[i] = 0; e_cv[i] = 0; e_lv[i] = 0; e_en[i] = 0; e_req[i] = '0; hist[i] = '0;
        end
        e_crd = '0; e_lrd = '0; busy = 0; starve = 0; lock = 0; c_pend = 0; l_pend = 0;
        drive_idle();
        reset = 1'b0;
        tick();
        @(negedge clock) reset = 1'b1;
        for (int t = 0; t < NCYC; t++) begin
            tick();
            if (e_cv[t]) e_crd = hist[t-1];
            if (e_lv[t]) e_lrd = hist[t-1];
            checks++;
            if ({cpu_gnt, ld_gnt, cpu_rvalid, ld_rvalid, mem_en} !== {e_cg[t], e_lg[t], e_cv[t], e_lv[t], e_en[t]}) begin
                errors++; $display("FAIL rand_strobes: cycle %0d got %b exp %b", t,
                                   {cpu_gnt, ld_gnt, cpu_rvalid, ld_rvalid, mem_en}, {e_cg[t], e_lg[t], e_cv[t], e_lv[t], e_en[t]});
            end
            if (e_en[t]) begin
                got = {mem_we, mem_addr, mem_wdata};
                checks++;
                if (got !== e_req[t]) begin
                    errors++; $display("FAIL rand_mem_access: cycle %0d got %h exp %h", t, got, e_req[t]);
                end
            end
            checks++;
            if ({cpu_rdata, ld_rdata} !== {e_crd, e_lrd}) begin
                errors++; $display("FAIL rand_rdata: cycle %0d got %h %h exp %h %h", t, cpu_rdata, ld_rdata, e_crd, e_lrd);
            end
            if (e_cg[t]) c_pend = 0;
            if (e_lg[t]) l_pend = 0;
            cpu_rate = (t < NCYC / 2) ? 1 : 3;
            if (!c_pend && $urandom_range(0, cpu_rate - 1) == 0) begin
                c_pend = 1; cpu_we = 1'($urandom); cpu_addr = 16'($urandom); cpu_wdata = 16'($urandom);
            end
            if (!l_pend && $urandom_range(0, 3) == 0) begin
                l_pend = 1; ld_we = 1'($urandom); ld_addr = 16'($urandom); ld_wdata = 16'($urandom);
            end
            cpu_req = c_pend;
            ld_req  = l_pend;
            if ($urandom_range(0, 19) == 0) ld_lock = ~ld_lock;
            mem_rdata = 16'($urandom);
            hist[t]   = mem_rdata;
            #1;
            checks++;
            if (cpu_stall !== (cpu_req && !e_cg[t])) begin
                errors++; $display("FAIL rand_stall: cycle %0d got %b exp %b", t, cpu_stall, cpu_req && !e_cg[t]);
            end
            // Arbiter is free to sample only when the previous transaction's cycle budget is spent.
            win = 0;
            if (busy == 0) begin
                if (lock)                                win = ld_req ? 2 : 0;
                else if (starve == int'(LIMIT) && ld_req) win = 2;
                else if (cpu_req)                        win = 1;
                else if (ld_req)                         win = 2;
                if (win == 1 && ld_req && starve < int'(LIMIT)) starve++;
                if (win == 2) starve = 0;
                if (win != 0) begin
                    e_en[t+1]  = 1;
                    e_cg[t+1]  = (win == 1);
                    e_lg[t+1]  = (win == 2);
                    e_req[t+1] = (win == 1) ? {cpu_we, cpu_addr, cpu_wdata} : {ld_we, ld_addr, ld_wdata};
                    if (e_req[t+1][32]) begin
                        busy = 1;
                    end else begin
                        busy = 1 + int'(RL);
                        if (win == 1) e_cv[t + 2 + int'(RL)] = 1;
                        else          e_lv[t + 2 + int'(RL)] = 1;
                    end
                end
            end else begin
                busy--;
            end
            if (!ld_lock)      lock = 0;
            else if (win == 2) lock = 1;
        end
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_simultaneous_writes();
        test_starvation();
        test_lock();
        test_reset_in_wait();
        test_latency3();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
